// File: rtl/risc_pkg.sv
// Shared definitions for the sequencer: opcodes, branch condition codes,
// PSR flag positions, instruction field positions and the FSM state type.
package risc_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_BRA = 4'h1;
    localparam logic [3:0] OP_LD  = 4'h2;
    localparam logic [3:0] OP_STR = 4'h3;
    localparam logic [3:0] OP_ADD = 4'h4;
    localparam logic [3:0] OP_SUB = 4'h5;
    localparam logic [3:0] OP_AND = 4'h6;
    localparam logic [3:0] OP_OR  = 4'h7;
    localparam logic [3:0] OP_XOR = 4'h8;
    localparam logic [3:0] OP_HLT = 4'h9;
    localparam logic [3:0] OP_SHL = 4'hA;
    localparam logic [3:0] OP_SHR = 4'hB;

    localparam logic [3:0] CC_ALWAYS = 4'd0;
    localparam logic [3:0] CC_CARRY  = 4'd1;
    localparam logic [3:0] CC_EVEN   = 4'd2;
    localparam logic [3:0] CC_PARITY = 4'd3;
    localparam logic [3:0] CC_ZERO   = 4'd4;
    localparam logic [3:0] CC_NEG    = 4'd5;

    localparam int PSR_CARRY  = 0;
    localparam int PSR_EVEN   = 1;
    localparam int PSR_PARITY = 2;
    localparam int PSR_ZERO   = 3;
    localparam int PSR_NEG    = 4;

    localparam int IR_OP_HI      = 31;
    localparam int IR_OP_LO      = 28;
    localparam int IR_CC_HI      = 27;
    localparam int IR_CC_LO      = 24;
    localparam int IR_IMM_BIT    = 27;
    localparam int IR_DSTMEM_BIT = 26;
    localparam int IR_SRC_HI     = 23;
    localparam int IR_SRC_LO     = 12;
    localparam int IR_DST_HI     = 11;
    localparam int IR_DST_LO     = 0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEMRD,
        S_WRITE,
        S_MEMWR,
        S_HALT
    } state_t;

    // Opcodes that are handed to the ALU
    function automatic logic isAluOp(input logic [3:0] op);
        return (op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR});
    endfunction

endpackage

// File: rtl/risc_cond_eval.sv
// Branch condition evaluator: maps a 4-bit condition code onto the PSR flags.
module risc_cond_eval
    import risc_pkg::*;
(
    input  logic [3:0] ccode,
    input  logic [4:0] psr,
    output logic       take
);

    // Code 0 always branches, 1..5 test a single flag, anything above never branches
    always_comb begin
        take = 1'b0;
        case (ccode)
            CC_ALWAYS: take = 1'b1;
            CC_CARRY:  take = psr[PSR_CARRY];
            CC_EVEN:   take = psr[PSR_EVEN];
            CC_PARITY: take = psr[PSR_PARITY];
            CC_ZERO:   take = psr[PSR_ZERO];
            CC_NEG:    take = psr[PSR_NEG];
            default:   take = 1'b0;
        endcase
    end

endmodule

// File: rtl/risc_seq_ctrl.sv
// Instruction sequencer for a small RISC core. Fetches from memory, decodes
// the opcode and steers the ALU, register-file write strobe and memory port.
// Every output is a flop, set on entry to the state that needs it.
module risc_seq_ctrl
    import risc_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int ADDRSIZE = 12
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDRSIZE-1:0] mem_addr,
    input  logic                mem_ack,
    input  logic [WIDTH-1:0]    mem_rdata,
    output logic [WIDTH-1:0]    ir,
    output logic [ADDRSIZE-1:0] pc,
    input  logic [4:0]          psr,
    output logic                alu_start,
    input  logic                alu_done,
    output logic                rf_we,
    output logic                halted,
    output logic                illegal
);

    state_t              state_q;
    logic [ADDRSIZE-1:0] pc_q;
    logic [WIDTH-1:0]    ir_q;
    logic                memReq_q;
    logic                memWe_q;
    logic [ADDRSIZE-1:0] memAddr_q;
    logic                aluStart_q;
    logic                rfWe_q;
    logic                halted_q;
    logic                illegal_q;

    logic [ADDRSIZE-1:0] pcInc_d;
    logic [ADDRSIZE-1:0] srcAddr;
    logic [ADDRSIZE-1:0] dstAddr;
    logic [3:0]          opcode;
    logic                take;

    // Field extraction from the instruction register and the sequential next pc
    always_comb begin
        pcInc_d = pc_q + ADDRSIZE'(1);
        srcAddr = ADDRSIZE'(ir_q[IR_SRC_HI:IR_SRC_LO]);
        dstAddr = ADDRSIZE'(ir_q[IR_DST_HI:IR_DST_LO]);
        opcode  = ir_q[IR_OP_HI:IR_OP_LO];
    end

    risc_cond_eval u_cond (
        .ccode (ir_q[IR_CC_HI:IR_CC_LO]),
        .psr   (psr),
        .take  (take)
    );

    // Main sequencer: state, pc, ir and all registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            ir_q       <= '0;
            memReq_q   <= 1'b0;
            memWe_q    <= 1'b0;
            memAddr_q  <= '0;
            aluStart_q <= 1'b0;
            rfWe_q     <= 1'b0;
            halted_q   <= 1'b0;
            illegal_q  <= 1'b0;
        end else begin
            aluStart_q <= 1'b0;
            rfWe_q     <= 1'b0;
            illegal_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        memReq_q  <= 1'b1;
                        memWe_q   <= 1'b0;
                        memAddr_q <= pc_q;
                        state_q   <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (mem_ack) begin
                        ir_q     <= mem_rdata;
                        pc_q     <= pcInc_d;
                        memReq_q <= 1'b0;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opcode)
                        OP_NOP: begin
                            memReq_q  <= 1'b1;
                            memWe_q   <= 1'b0;
                            memAddr_q <= pc_q;
                            state_q   <= S_FETCH;
                        end
                        OP_BRA: begin
                            memReq_q <= 1'b1;
                            memWe_q  <= 1'b0;
                            state_q  <= S_FETCH;
                            if (take) begin
                                pc_q      <= dstAddr;
                                memAddr_q <= dstAddr;
                            end else begin
                                memAddr_q <= pc_q;
                            end
                        end
                        OP_LD: begin
                            if (ir_q[IR_IMM_BIT]) begin
                                rfWe_q  <= 1'b1;
                                state_q <= S_WRITE;
                            end else begin
                                memReq_q  <= 1'b1;
                                memWe_q   <= 1'b0;
                                memAddr_q <= srcAddr;
                                state_q   <= S_MEMRD;
                            end
                        end
                        OP_STR: begin
                            memReq_q  <= 1'b1;
                            memWe_q   <= 1'b1;
                            memAddr_q <= dstAddr;
                            state_q   <= S_MEMWR;
                        end
                        OP_HLT: begin
                            halted_q <= 1'b1;
                            state_q  <= S_HALT;
                        end
                        default: begin
                            if (isAluOp(opcode)) begin
                                aluStart_q <= 1'b1;
                                state_q    <= S_EXEC;
                            end else begin
                                illegal_q <= 1'b1;
                                memReq_q  <= 1'b1;
                                memWe_q   <= 1'b0;
                                memAddr_q <= pc_q;
                                state_q   <= S_FETCH;
                            end
                        end
                    endcase
                end
                S_EXEC: begin
                    if (alu_done) begin
                        if (ir_q[IR_DSTMEM_BIT]) begin
                            memReq_q  <= 1'b1;
                            memWe_q   <= 1'b1;
                            memAddr_q <= dstAddr;
                            state_q   <= S_MEMWR;
                        end else begin
                            rfWe_q  <= 1'b1;
                            state_q <= S_WRITE;
                        end
                    end
                end
                S_MEMRD: begin
                    if (mem_ack) begin
                        memReq_q <= 1'b0;
                        rfWe_q   <= 1'b1;
                        state_q  <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    memReq_q  <= 1'b1;
                    memWe_q   <= 1'b0;
                    memAddr_q <= pc_q;
                    state_q   <= S_FETCH;
                end
                S_MEMWR: begin
                    if (mem_ack) begin
                        memReq_q  <= 1'b1;
                        memWe_q   <= 1'b0;
                        memAddr_q <= pc_q;
                        state_q   <= S_FETCH;
                    end
                end
                S_HALT: begin
                    halted_q <= 1'b1;
                    memReq_q <= 1'b0;
                    memWe_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs come straight from flops
    always_comb begin
        mem_req   = memReq_q;
        mem_we    = memWe_q;
        mem_addr  = memAddr_q;
        ir        = ir_q;
        pc        = pc_q;
        alu_start = aluStart_q;
        rf_we     = rfWe_q;
        halted    = halted_q;
        illegal   = illegal_q;
    end

endmodule

// File: tb/tb_risc_seq_ctrl.sv
// Self-checking bench for risc_seq_ctrl. A memory/ALU responder answers the
// DUT and scores each completed memory access against an expected queue.
module tb_risc_seq_ctrl;

    typedef struct {
        logic [11:0] addr;
        logic        we;
    } memExp_t;

    typedef struct {
        logic [4:0]  psrVal;
        logic [3:0]  cc;
        logic [11:0] dst;
        logic [11:0] nextFetch;
    } brCase_t;

    typedef struct {
        int          aluD;
        logic [31:0] instr;
        logic        dstMem;
        int          expDiff;
    } aluCase_t;

    typedef struct {
        logic [31:0] instr;
        int          ackD;
        logic        hasMem;
        logic [11:0] memAddr;
        logic        memWe;
        int          expRf;
    } lsCase_t;

    localparam logic [31:0] INSTR_NOP = 32'h0000_0000;
    localparam logic [31:0] INSTR_HLT = 32'h9000_0000;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        mem_req;
    logic        mem_we;
    logic [11:0] mem_addr;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic [31:0] ir;
    logic [11:0] pc;
    logic [4:0]  psr = 5'b0;
    logic        alu_start;
    logic        alu_done = 1'b0;
    logic        rf_we;
    logic        halted;
    logic        illegal;

    int checks = 0;
    int fails = 0;
    int cyc = 0;
    int ackDelay = 0;
    int aluDelay = 0;
    bit forceAck = 1'b0;
    int waitCnt = 0;
    bit aluPending = 1'b0;
    int aluWait = 0;
    int aluStartCnt = 0;
    int rfWeCnt = 0;
    int illegalCnt = 0;
    int stabErr = 0;
    int startCyc = 0;
    int doneCyc = 0;
    int rfCyc = 0;
    int ackCycQ[$];
    logic [31:0] mem [int];
    memExp_t expQ[$];

    always #5 clk = ~clk;

    risc_seq_ctrl #(.WIDTH(32), .ADDRSIZE(12)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .ir        (ir),
        .pc        (pc),
        .psr       (psr),
        .alu_start (alu_start),
        .alu_done  (alu_done),
        .rf_we     (rf_we),
        .halted    (halted),
        .illegal   (illegal)
    );

    // Memory and ALU responder plus access scoreboard, all on the falling edge
    initial begin
        bit          oldAck;
        bit          reqSeen;
        logic [11:0] prevAddr;
        logic        prevWe;
        memExp_t     e;
        reqSeen = 1'b0;
        prevAddr = 12'h0;
        prevWe = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            oldAck = mem_ack;
            if (alu_start === 1'b1) begin
                aluStartCnt++;
                startCyc = cyc;
                aluWait = aluDelay;
                aluPending = 1'b1;
            end
            if (rf_we === 1'b1) begin
                rfWeCnt++;
                rfCyc = cyc;
            end
            if (illegal === 1'b1) illegalCnt++;
            alu_done = 1'b0;
            if (aluPending) begin
                if (aluWait == 0) begin
                    alu_done = 1'b1;
                    doneCyc = cyc;
                    aluPending = 1'b0;
                end else begin
                    aluWait--;
                end
            end
            if (oldAck) waitCnt = 0;
            if (forceAck) begin
                mem_ack = 1'b1;
            end else if (mem_req === 1'b1) begin
                if (reqSeen && !oldAck && (mem_addr !== prevAddr || mem_we !== prevWe)) stabErr++;
                if (waitCnt >= ackDelay) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'h0;
                    ackCycQ.push_back(cyc);
                    checks++;
                    if (expQ.size() == 0) begin
                        fails++;
                        $display("[TB] FAIL memTxn: got access addr=%03h we=%0b, expected no access", mem_addr, mem_we);
                    end else begin
                        e = expQ.pop_front();
                        if (mem_addr !== e.addr || mem_we !== e.we) begin
                            fails++;
                            $display("[TB] FAIL memTxn: got addr=%03h we=%0b, expected addr=%03h we=%0b",
                                     mem_addr, mem_we, e.addr, e.we);
                        end
                    end
                end else begin
                    mem_ack = 1'b0;
                    waitCnt++;
                end
            end else begin
                mem_ack = 1'b0;
                waitCnt = 0;
            end
            reqSeen = (mem_req === 1'b1);
            prevAddr = mem_addr;
            prevWe = mem_we;
        end
    end

    // Advance one cycle and settle mid-cycle, away from both clock edges
    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    // Reset the DUT, set the environment and pulse start for one cycle
    task automatic applyStimulus(input logic [4:0] psrVal, input int ackD, input int aluD);
        reset_n = 1'b0;
        start = 1'b0;
        psr = psrVal;
        ackDelay = ackD;
        aluDelay = aluD;
        aluStartCnt = 0;
        rfWeCnt = 0;
        illegalCnt = 0;
        stabErr = 0;
        aluPending = 1'b0;
        ackCycQ.delete();
        repeat (2) tick();
        reset_n = 1'b1;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        forceAck = 1'b1;
        tick();
        checks++;
        if ({mem_req, mem_we, alu_start, rf_we, halted, illegal} !== 6'b0) begin
            fails++;
            $display("[TB] FAIL resetStrobes: got %06b expected 000000",
                     {mem_req, mem_we, alu_start, rf_we, halted, illegal});
        end
        checks++;
        if (pc !== 12'h0) begin
            fails++;
            $display("[TB] FAIL resetPc: got %03h expected 000", pc);
        end
        checks++;
        if (ir !== 32'h0) begin
            fails++;
            $display("[TB] FAIL resetIr: got %08h expected 00000000", ir);
        end
        reset_n = 1'b1;
        repeat (5) tick();
        checks++;
        if (mem_req !== 1'b0 || pc !== 12'h0 || ir !== 32'h0) begin
            fails++;
            $display("[TB] FAIL idleIgnoresAck: got req=%0b pc=%03h ir=%08h expected 0/000/00000000", mem_req, pc, ir);
        end
        forceAck = 1'b0;
        tick();
    endtask

    task automatic test_nop();
        int diff;
        mem.delete();
        expQ.delete();
        mem[0] = INSTR_NOP;
        mem[1] = INSTR_HLT;
        expQ.push_back('{12'h000, 1'b0});
        expQ.push_back('{12'h001, 1'b0});
        applyStimulus(5'b0, 0, 0);
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        checks++;
        if (halted !== 1'b1) begin
            fails++;
            $display("[TB] FAIL nopHalt: got halted=%0b expected 1", halted);
        end
        checks++;
        if (pc !== 12'h002 || ir !== INSTR_HLT) begin
            fails++;
            $display("[TB] FAIL nopPcIr: got pc=%03h ir=%08h expected 002/%08h", pc, ir, INSTR_HLT);
        end
        diff = (ackCycQ.size() == 2) ? ackCycQ[1] - ackCycQ[0] : -1;
        checks++;
        if (diff != 2) begin
            fails++;
            $display("[TB] FAIL nopLatency: got %0d cycles expected 2", diff);
        end
        checks++;
        if (expQ.size() != 0 || illegalCnt != 0 || rfWeCnt != 0) begin
            fails++;
            $display("[TB] FAIL nopLeftover: got pending=%0d illegal=%0d rfwe=%0d expected 0/0/0",
                     expQ.size(), illegalCnt, rfWeCnt);
        end
    endtask

    task automatic test_branch();
        brCase_t tab [5];
        tab = '{'{5'b01000, 4'd4, 12'h123, 12'h123},
                '{5'b00000, 4'd4, 12'h123, 12'h001},
                '{5'b11111, 4'd7, 12'h300, 12'h001},
                '{5'b00000, 4'd0, 12'h050, 12'h050},
                '{5'b10000, 4'd5, 12'h7FE, 12'h7FE}};
        for (int k = 0; k < 5; k++) begin
            mem.delete();
            expQ.delete();
            mem[0] = {4'h1, tab[k].cc, 12'h000, tab[k].dst};
            mem[1] = INSTR_HLT;
            mem[int'(tab[k].dst)] = INSTR_HLT;
            expQ.push_back('{12'h000, 1'b0});
            expQ.push_back('{tab[k].nextFetch, 1'b0});
            applyStimulus(tab[k].psrVal, 0, 0);
            for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
            checks++;
            if (halted !== 1'b1 || expQ.size() != 0) begin
                fails++;
                $display("[TB] FAIL branch%0d: got halted=%0b pending=%0d expected 1/0", k, halted, expQ.size());
            end
            checks++;
            if (pc !== tab[k].nextFetch + 12'h1) begin
                fails++;
                $display("[TB] FAIL branchPc%0d: got %03h expected %03h", k, pc, tab[k].nextFetch + 12'h1);
            end
        end
    endtask

    task automatic test_alu();
        aluCase_t tab [3];
        int diff;
        tab = '{'{3, 32'h4000_0ABC, 1'b0, 7},
                '{0, 32'hB000_0ABC, 1'b0, 4},
                '{3, 32'h4400_0ABC, 1'b1, 7}};
        for (int k = 0; k < 3; k++) begin
            mem.delete();
            expQ.delete();
            mem[0] = tab[k].instr;
            mem[1] = INSTR_HLT;
            expQ.push_back('{12'h000, 1'b0});
            if (tab[k].dstMem) expQ.push_back('{12'hABC, 1'b1});
            expQ.push_back('{12'h001, 1'b0});
            applyStimulus(5'b0, 0, tab[k].aluD);
            for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
            checks++;
            if (halted !== 1'b1 || expQ.size() != 0) begin
                fails++;
                $display("[TB] FAIL alu%0d: got halted=%0b pending=%0d expected 1/0", k, halted, expQ.size());
            end
            checks++;
            if (aluStartCnt != 1 || rfWeCnt != (tab[k].dstMem ? 0 : 1)) begin
                fails++;
                $display("[TB] FAIL aluPulses%0d: got start=%0d rfwe=%0d expected 1/%0d",
                         k, aluStartCnt, rfWeCnt, tab[k].dstMem ? 0 : 1);
            end
            diff = (ackCycQ.size() >= 2) ? ackCycQ[ackCycQ.size()-1] - ackCycQ[0] : -1;
            checks++;
            if (diff != tab[k].expDiff) begin
                fails++;
                $display("[TB] FAIL aluLatency%0d: got %0d cycles expected %0d", k, diff, tab[k].expDiff);
            end
            if (!tab[k].dstMem) begin
                checks++;
                if (rfCyc - doneCyc != 1 || rfCyc - startCyc != tab[k].aluD + 1) begin
                    fails++;
                    $display("[TB] FAIL aluRfTiming%0d: got done->rf=%0d start->rf=%0d expected 1/%0d",
                             k, rfCyc - doneCyc, rfCyc - startCyc, tab[k].aluD + 1);
                end
            end
        end
    endtask

    task automatic test_load_store();
        lsCase_t tab [3];
        tab = '{'{32'h2001_0005, 2, 1'b1, 12'h010, 1'b0, 1},
                '{32'h2801_0005, 2, 1'b0, 12'h000, 1'b0, 1},
                '{32'h3000_0077, 1, 1'b1, 12'h077, 1'b1, 0}};
        for (int k = 0; k < 3; k++) begin
            mem.delete();
            expQ.delete();
            mem[0] = tab[k].instr;
            mem[1] = INSTR_HLT;
            expQ.push_back('{12'h000, 1'b0});
            if (tab[k].hasMem) expQ.push_back('{tab[k].memAddr, tab[k].memWe});
            expQ.push_back('{12'h001, 1'b0});
            applyStimulus(5'b0, tab[k].ackD, 0);
            for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
            checks++;
            if (halted !== 1'b1 || expQ.size() != 0) begin
                fails++;
                $display("[TB] FAIL ldst%0d: got halted=%0b pending=%0d expected 1/0", k, halted, expQ.size());
            end
            checks++;
            if (rfWeCnt != tab[k].expRf || stabErr != 0) begin
                fails++;
                $display("[TB] FAIL ldstStrobe%0d: got rfwe=%0d unstable=%0d expected %0d/0",
                         k, rfWeCnt, stabErr, tab[k].expRf);
            end
        end
    endtask

    task automatic test_wrap_illegal_halt();
        int busy;
        mem.delete();
        expQ.delete();
        mem[0] = 32'h1000_0FFF;
        mem[12'hFFF] = INSTR_NOP;
        expQ.push_back('{12'h000, 1'b0});
        expQ.push_back('{12'hFFF, 1'b0});
        expQ.push_back('{12'h000, 1'b0});
        applyStimulus(5'b0, 0, 0);
        for (int i = 0; i < 50 && ackCycQ.size() < 1; i++) tick();
        mem[0] = INSTR_HLT;
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        checks++;
        if (halted !== 1'b1 || expQ.size() != 0 || pc !== 12'h001) begin
            fails++;
            $display("[TB] FAIL pcWrap: got halted=%0b pending=%0d pc=%03h expected 1/0/001", halted, expQ.size(), pc);
        end

        mem.delete();
        expQ.delete();
        mem[0] = 32'hF000_0000;
        mem[1] = INSTR_HLT;
        expQ.push_back('{12'h000, 1'b0});
        expQ.push_back('{12'h001, 1'b0});
        applyStimulus(5'b0, 0, 0);
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        checks++;
        if (illegalCnt != 1 || halted !== 1'b1 || pc !== 12'h002) begin
            fails++;
            $display("[TB] FAIL illegal: got pulses=%0d halted=%0b pc=%03h expected 1/1/002", illegalCnt, halted, pc);
        end

        busy = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (mem_req !== 1'b0 || alu_start !== 1'b0 || rf_we !== 1'b0 || halted !== 1'b1) busy++;
        end
        checks++;
        if (busy != 0) begin
            fails++;
            $display("[TB] FAIL haltQuiet: got %0d active cycles expected 0", busy);
        end
    endtask

    task automatic test_reset_midwrite();
        mem.delete();
        expQ.delete();
        mem[0] = 32'h3000_0077;
        expQ.push_back('{12'h000, 1'b0});
        applyStimulus(5'b0, 0, 0);
        for (int i = 0; i < 50 && ackCycQ.size() < 1; i++) tick();
        ackDelay = 40;
        for (int i = 0; i < 50 && !(mem_req === 1'b1 && mem_we === 1'b1); i++) tick();
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 12'h077) begin
            fails++;
            $display("[TB] FAIL memwrWait: got req=%0b we=%0b addr=%03h expected 1/1/077", mem_req, mem_we, mem_addr);
        end
        repeat (2) tick();
        reset_n = 1'b0;
        #1;
        checks++;
        if (mem_req !== 1'b0 || mem_we !== 1'b0 || pc !== 12'h0 || ir !== 32'h0) begin
            fails++;
            $display("[TB] FAIL asyncReset: got req=%0b we=%0b pc=%03h ir=%08h expected 0/0/000/00000000",
                     mem_req, mem_we, pc, ir);
        end
        tick();
        reset_n = 1'b1;
        ackDelay = 0;
        repeat (5) tick();
        checks++;
        if (mem_req !== 1'b0 || halted !== 1'b0) begin
            fails++;
            $display("[TB] FAIL waitStart: got req=%0b halted=%0b expected 0/0", mem_req, halted);
        end
        mem[0] = INSTR_HLT;
        expQ.push_back('{12'h000, 1'b0});
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 200 && halted !== 1'b1; i++) tick();
        checks++;
        if (halted !== 1'b1 || pc !== 12'h001 || expQ.size() != 0) begin
            fails++;
            $display("[TB] FAIL restart: got halted=%0b pc=%03h pending=%0d expected 1/001/0", halted, pc, expQ.size());
        end
    endtask

    // Run every scenario in turn, then report
    initial begin
        test_reset();
        test_nop();
        test_branch();
        test_alu();
        test_load_store();
        test_wrap_illegal_halt();
        test_reset_midwrite();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Hard stop in case the sequence above never completes
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no end of test, expected completion within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
